lpgbt_uplink_snapshot: RTL and testbench

Downstream consumer of the lpGBT-FPGA uplink, running in the recovered 40 MHz frame clock domain. Captures a burst of up to DEPTH consecutive valid 234-bit uplink frames into on-chip memory after a pattern or software trigger. It also maintains saturating valid-frame and FEC-error counters. Control and readback are synchronous to clk40_i; CDC to the AXI control registers is done by the instantiating wrapper.

---
 rtl/lpgbt_uplink_pkg.sv | 22 ++
 rtl/lpgbt_snapshot_ram.sv | 28 ++
 rtl/lpgbt_uplink_snapshot.sv | 152 +++++++++++++++
 tb/tb_lpgbt_uplink_snapshot.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpgbt_uplink_pkg.sv
// Shared constants, state encoding and frame padding helper for the uplink snapshot.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lpgbt_uplink_pkg;

  localparam int UPLINK_DATA_W = 234;
  localparam int UPLINK_WORDS  = 8;
  localparam int UPLINK_PAD_W  = 32 * UPLINK_WORDS;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } snap_state_e;

  // Zero-extend a 234-bit frame to eight full 32-bit words.
  function automatic logic [UPLINK_PAD_W-1:0] pad_frame(input logic [UPLINK_DATA_W-1:0] d);
    return {{(UPLINK_PAD_W - UPLINK_DATA_W){1'b0}}, d};
  endfunction

endpackage

// File: rtl/lpgbt_snapshot_ram.sv
// Simple dual-port frame buffer, one padded 256-bit frame per entry, no reset.
// Latency: 1 cycle registered read; read-first on a same-address write.
// Backpressure: none, accepts a write and a read every cycle.
module lpgbt_snapshot_ram
  import lpgbt_uplink_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    wr_vld,
  input  logic [AW-1:0]           wr_addr,
  input  logic [UPLINK_PAD_W-1:0] wr_dat,
  input  logic [AW-1:0]           rd_addr,
  output logic [UPLINK_PAD_W-1:0] rd_dat
);

  logic [UPLINK_PAD_W-1:0] mem [DEPTH];

  // Write and registered read share one edge, so a colliding read sees the old entry.
  always_ff @(posedge clk) begin
    if (wr_vld) begin
      mem[wr_addr] <= wr_dat;
    end
    rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/lpgbt_uplink_snapshot.sv
// Triggered burst capture of lpGBT uplink frames plus saturating frame/FEC counters.
// Latency: frame stored on the edge it is valid; readback 2 cycles after rd_addr_i.
// Backpressure: none; invalid frames are skipped and flagged via rdy_gap_o.
module lpgbt_uplink_snapshot
  import lpgbt_uplink_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int CNT_W = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                     clk40_i,
  input  logic                     rst_i,
  input  logic                     uplinkrdy_i,
  input  logic [UPLINK_DATA_W-1:0] uplinkUserData_i,
  input  logic                     uplinkFEC_i,
  input  logic                     arm_i,
  input  logic                     sw_trig_i,
  input  logic [2:0]               trig_word_sel_i,
  input  logic [31:0]              trig_mask_i,
  input  logic [31:0]              trig_pattern_i,
  input  logic [AW-1:0]            capture_len_i,
  input  logic                     clr_cnt_i,
  output logic [1:0]               state_o,
  output logic                     done_o,
  output logic                     rdy_gap_o,
  output logic [AW:0]              wr_count_o,
  output logic [CNT_W-1:0]         frame_cnt_o,
  output logic [CNT_W-1:0]         fec_err_cnt_o,
  input  logic [AW+2:0]            rd_addr_i,
  output logic [31:0]              rd_data_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  snap_state_e             state;
  logic [AW:0]             wr_count;
  logic [AW:0]             wr_nxt;
  logic [AW:0]             eff_len;
  logic [UPLINK_PAD_W-1:0] frame_pad;
  logic [31:0]             window;
  logic                    valid;
  logic                    match;
  logic                    trig_hit;
  logic                    wr_vld;
  logic [AW-1:0]           wr_addr;
  logic [UPLINK_PAD_W-1:0] ram_rd_dat;
  logic [2:0]              word_q;

  assign valid     = uplinkrdy_i;
  assign frame_pad = pad_frame(uplinkUserData_i);
  assign window    = frame_pad[{trig_word_sel_i, 5'd0} +: 32];
  assign match     = ((window & trig_mask_i) == (trig_pattern_i & trig_mask_i));
  assign trig_hit  = valid && (match || sw_trig_i);
  assign eff_len   = (capture_len_i == '0) ? (AW+1)'(DEPTH) : {1'b0, capture_len_i};
  assign wr_nxt    = wr_count + 1'b1;

  // Store on the trigger frame in ARMED and on every valid frame in CAPTURE; arm or reset blocks the write.
  always_comb begin
    wr_vld  = 1'b0;
    wr_addr = '0;
    if (!rst_i && !arm_i) begin
      if (state == ST_ARMED) begin
        wr_vld  = trig_hit;
        wr_addr = '0;
      end else if (state == ST_CAPTURE) begin
        wr_vld  = valid;
        wr_addr = wr_count[AW-1:0];
      end
    end
  end

  // Capture FSM; arm wins over any trigger or write in the same cycle.
  always_ff @(posedge clk40_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      wr_count  <= '0;
      rdy_gap_o <= 1'b0;
    end else if (arm_i) begin
      state     <= ST_ARMED;
      wr_count  <= '0;
      rdy_gap_o <= 1'b0;
    end else begin
      case (state)
        ST_ARMED: begin
          if (trig_hit) begin
            wr_count <= (AW+1)'(1);
            state    <= (eff_len == (AW+1)'(1)) ? ST_DONE : ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (valid) begin
            wr_count <= wr_nxt;
            if (wr_nxt == eff_len) begin
              state <= ST_DONE;
            end
          end else begin
            rdy_gap_o <= 1'b1;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

  assign state_o    = state;
  assign done_o     = (state == ST_DONE);
  assign wr_count_o = wr_count;

  // Saturating count of valid frames; clear beats increment.
  always_ff @(posedge clk40_i) begin
    if (rst_i || clr_cnt_i) begin
      frame_cnt_o <= '0;
    end else if (valid && frame_cnt_o != CNT_MAX) begin
      frame_cnt_o <= frame_cnt_o + 1'b1;
    end
  end

  // Saturating count of valid frames that needed FEC correction; clear beats increment.
  always_ff @(posedge clk40_i) begin
    if (rst_i || clr_cnt_i) begin
      fec_err_cnt_o <= '0;
    end else if (valid && uplinkFEC_i && fec_err_cnt_o != CNT_MAX) begin
      fec_err_cnt_o <= fec_err_cnt_o + 1'b1;
    end
  end

  lpgbt_snapshot_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk40_i),
    .wr_vld  (wr_vld),
    .wr_addr (wr_addr),
    .wr_dat  (frame_pad),
    .rd_addr (rd_addr_i[AW+2:3]),
    .rd_dat  (ram_rd_dat)
  );

  // Word select travels alongside the RAM read, then the selected word is registered out.
  always_ff @(posedge clk40_i) begin
    if (rst_i) begin
      word_q    <= '0;
      rd_data_o <= '0;
    end else begin
      word_q    <= rd_addr_i[2:0];
      rd_data_o <= ram_rd_dat[{word_q, 5'd0} +: 32];
    end
  end

endmodule

// File: tb/tb_lpgbt_uplink_snapshot.sv
module tb_lpgbt_uplink_snapshot;

  localparam int DEPTH = 64;
  localparam int CNT_W = 4;
  localparam int AW    = 6;

  logic           clk40_i = 1'b0;
  logic           rst_i = 1'b1;
  logic           uplinkrdy_i = 1'b0;
  logic [233:0]   uplinkUserData_i = '0;
  logic           uplinkFEC_i = 1'b0;
  logic           arm_i = 1'b0;
  logic           sw_trig_i = 1'b0;
  logic [2:0]     trig_word_sel_i = '0;
  logic [31:0]    trig_mask_i = '0;
  logic [31:0]    trig_pattern_i = '0;
  logic [AW-1:0]  capture_len_i = '0;
  logic           clr_cnt_i = 1'b0;
  logic [1:0]     state_o;
  logic           done_o;
  logic           rdy_gap_o;
  logic [AW:0]    wr_count_o;
  logic [CNT_W-1:0] frame_cnt_o;
  logic [CNT_W-1:0] fec_err_cnt_o;
  logic [AW+2:0]  rd_addr_i = '0;
  logic [31:0]    rd_data_o;

  lpgbt_uplink_snapshot #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk40_i          (clk40_i),
    .rst_i            (rst_i),
    .uplinkrdy_i      (uplinkrdy_i),
    .uplinkUserData_i (uplinkUserData_i),
    .uplinkFEC_i      (uplinkFEC_i),
    .arm_i            (arm_i),
    .sw_trig_i        (sw_trig_i),
    .trig_word_sel_i  (trig_word_sel_i),
    .trig_mask_i      (trig_mask_i),
    .trig_pattern_i   (trig_pattern_i),
    .capture_len_i    (capture_len_i),
    .clr_cnt_i        (clr_cnt_i),
    .state_o          (state_o),
    .done_o           (done_o),
    .rdy_gap_o        (rdy_gap_o),
    .wr_count_o       (wr_count_o),
    .frame_cnt_o      (frame_cnt_o),
    .fec_err_cnt_o    (fec_err_cnt_o),
    .rd_addr_i        (rd_addr_i),
    .rd_data_o        (rd_data_o)
  );

  always #5 clk40_i = ~clk40_i;

  localparam int K_STATE = 0, K_DONE = 1, K_GAP = 2, K_WR = 3, K_FC = 4, K_FEC = 5, K_RD = 6;

  typedef struct {
    int          kind;
    string       nm;
    logic [31:0] exp;
  } chk_t;

  chk_t        st_q[$];
  chk_t        rd_q[$];
  int          checks = 0;
  int          failures = 0;
  logic        rd_issue = 1'b0;
  logic        rd_p0 = 1'b0;
  logic        rd_p1 = 1'b0;
  logic [233:0] ones = '1;

  // Frame n: index in [31:8], 0xA5 in [7:0] from n=10 on, tag word in [63:32].
  function automatic logic [233:0] mkf(input int n);
    logic [233:0] f;
    f = '0;
    f[31:8]  = 24'(n);
    f[7:0]   = (n >= 10) ? 8'hA5 : 8'h00;
    f[63:32] = 32'hC0DE0000 | 32'(n);
    return f;
  endfunction

  function automatic logic [31:0] actual(input int kind);
    case (kind)
      K_STATE: return 32'(state_o);
      K_DONE:  return 32'(done_o);
      K_GAP:   return 32'(rdy_gap_o);
      K_WR:    return 32'(wr_count_o);
      K_FC:    return 32'(frame_cnt_o);
      K_FEC:   return 32'(fec_err_cnt_o);
      default: return rd_data_o;
    endcase
  endfunction

  // Read pipeline tag, two edges deep to match the readback latency.
  always @(posedge clk40_i) begin
    rd_p0 <= rd_issue;
    rd_p1 <= rd_p0;
  end

  // Monitor: compares queued expectations against DUT outputs away from the active edge.
  always @(negedge clk40_i) begin
    chk_t c;
    logic [31:0] a;
    while (st_q.size() > 0) begin
      c = st_q.pop_front();
      a = actual(c.kind);
      checks++;
      if (a !== c.exp) begin
        failures++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", c.nm, a, c.exp);
      end
    end
    if (rd_p1) begin
      checks++;
      if (rd_q.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected: got 0x%08h expected no read", rd_data_o);
      end else begin
        c = rd_q.pop_front();
        if (rd_data_o !== c.exp) begin
          failures++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", c.nm, rd_data_o, c.exp);
        end
      end
    end
  end

  task automatic chk(input int kind, input string nm, input logic [31:0] exp);
    chk_t c;
    c.kind = kind; c.nm = nm; c.exp = exp;
    st_q.push_back(c);
  endtask

  task automatic cyc(input logic rdy, input logic [233:0] d, input logic fec,
                     input logic arm, input logic sw, input logic clr);
    uplinkrdy_i = rdy; uplinkUserData_i = d; uplinkFEC_i = fec;
    arm_i = arm; sw_trig_i = sw; clr_cnt_i = clr;
    @(posedge clk40_i); #1;
    rd_issue = 1'b0;
    arm_i = 1'b0; sw_trig_i = 1'b0; clr_cnt_i = 1'b0;
  endtask

  task automatic frm(input int n);
    cyc(1'b1, mkf(n), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic arm();
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic rd_set(input int idx, input int w, input string nm, input logic [31:0] exp);
    chk_t c;
    c.kind = K_RD; c.nm = nm; c.exp = exp;
    rd_q.push_back(c);
    rd_addr_i = {6'(idx), 3'(w)};
    rd_issue  = 1'b1;
  endtask

  task automatic rd(input int idx, input int w, input string nm, input logic [31:0] exp);
    rd_set(idx, w, nm, exp);
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset
    @(posedge clk40_i); #1;
    rst_i = 1'b1;
    repeat (3) idle();
    chk(K_STATE, "rst_state", 0); chk(K_DONE, "rst_done", 0); chk(K_GAP, "rst_gap", 0);
    chk(K_WR, "rst_wr", 0); chk(K_FC, "rst_fc", 0); chk(K_FEC, "rst_fec", 0);
    chk(K_RD, "rst_rd", 0);
    rst_i = 1'b0;
    idle();
    chk(K_STATE, "idle_hold", 0);

    // Pattern trigger, window 0, length 4
    trig_word_sel_i = 3'd0; trig_mask_i = 32'hFF; trig_pattern_i = 32'hA5; capture_len_i = 6'd4;
    arm();
    chk(K_STATE, "pt_armed", 1);
    for (int n = 0; n < 10; n++) frm(n);
    chk(K_STATE, "pt_still_armed", 1); chk(K_WR, "pt_wr0", 0);
    frm(10);
    chk(K_STATE, "pt_capture", 2); chk(K_WR, "pt_wr1", 1);
    for (int n = 11; n < 14; n++) frm(n);
    chk(K_STATE, "pt_done_state", 3); chk(K_DONE, "pt_done", 1); chk(K_WR, "pt_wr4", 4);
    frm(14);
    chk(K_WR, "pt_done_blocks", 4); chk(K_STATE, "pt_done_hold", 3);
    rd(0, 0, "pt_e0w0", 32'h00000AA5);
    rd(3, 0, "pt_e3w0", 32'h00000DA5);
    rd(1, 1, "pt_e1w1", 32'hC0DE000B);
    idle(); idle();

    // Ready gap inside capture
    arm();
    chk(K_GAP, "gap_cleared", 0); chk(K_WR, "gap_wr_cleared", 0);
    for (int n = 0; n < 12; n++) frm(n);
    chk(K_STATE, "gap_capture", 2); chk(K_WR, "gap_wr2", 2); chk(K_GAP, "gap_none_yet", 0);
    cyc(1'b0, mkf(99), 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, mkf(99), 1'b0, 1'b0, 1'b0, 1'b0);
    chk(K_GAP, "gap_set", 1); chk(K_WR, "gap_wr_hold", 2); chk(K_STATE, "gap_still_cap", 2);
    frm(12); frm(13);
    chk(K_STATE, "gap_done", 3); chk(K_WR, "gap_wr4", 4); chk(K_GAP, "gap_sticky", 1);
    rd(0, 0, "gap_e0", 32'h00000AA5);
    rd(1, 0, "gap_e1", 32'h00000BA5);
    rd(2, 0, "gap_e2", 32'h00000CA5);
    rd(3, 0, "gap_e3", 32'h00000DA5);
    idle(); idle();

    // Effective length 1 goes straight to DONE
    trig_mask_i = 32'h0; capture_len_i = 6'd1;
    arm();
    frm(50);
    chk(K_STATE, "len1_done", 3); chk(K_WR, "len1_wr", 1);
    rd(0, 0, "len1_e0", 32'h000032A5);
    idle(); idle();

    // Software trigger rules, then full-depth capture (len 0)
    rst_i = 1'b1; idle(); rst_i = 1'b0;
    chk(K_STATE, "sw_rst_idle", 0); chk(K_WR, "sw_rst_wr", 0);
    trig_mask_i = 32'hFFFFFFFF; trig_pattern_i = 32'hFFFFFFFF; capture_len_i = 6'd0;
    cyc(1'b1, mkf(5), 1'b0, 1'b0, 1'b1, 1'b0);
    chk(K_STATE, "sw_idle_ignored", 0);
    arm();
    cyc(1'b0, mkf(6), 1'b0, 1'b0, 1'b1, 1'b0);
    chk(K_STATE, "sw_norddy_ignored", 1);
    frm(7);
    chk(K_STATE, "sw_nomatch_armed", 1);
    rd_set(0, 0, "sw_read_first", 32'h000032A5);
    cyc(1'b1, mkf(100), 1'b0, 1'b0, 1'b1, 1'b0);
    chk(K_STATE, "sw_capture", 2); chk(K_WR, "sw_wr1", 1);
    for (int n = 101; n < 163; n++) frm(n);
    chk(K_STATE, "full_cap", 2); chk(K_WR, "full_wr63", 63);
    frm(163);
    chk(K_STATE, "full_done", 3); chk(K_WR, "full_wr64", 64); chk(K_DONE, "full_done_o", 1);
    rd(0, 0, "full_e0", 32'h000064A5);
    rd(63, 0, "full_e63w0", 32'h0000A3A5);
    rd(63, 1, "full_e63w1", 32'hC0DE00A3);
    idle(); idle();

    // Saturating counters
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk(K_FC, "cnt_clr_fc", 0); chk(K_FEC, "cnt_clr_fec", 0);
    for (int i = 0; i < 5; i++) cyc(1'b1, mkf(i), 1'b1, 1'b0, 1'b0, 1'b0);
    chk(K_FC, "cnt_fc5", 5); chk(K_FEC, "cnt_fec5", 5);
    for (int i = 5; i < 20; i++) cyc(1'b1, mkf(i), 1'b1, 1'b0, 1'b0, 1'b0);
    chk(K_FC, "cnt_fc_sat", 15); chk(K_FEC, "cnt_fec_sat", 15);
    cyc(1'b1, mkf(1), 1'b1, 1'b0, 1'b0, 1'b1);
    chk(K_FC, "cnt_clr_wins_fc", 0); chk(K_FEC, "cnt_clr_wins_fec", 0);
    frm(2);
    chk(K_FC, "cnt_fc1", 1); chk(K_FEC, "cnt_nofec", 0);
    idle();
    chk(K_FC, "cnt_invalid_hold", 1);

    // Re-arm mid-capture, then capture an all-ones frame through window 7
    trig_word_sel_i = 3'd0; trig_mask_i = 32'h0; capture_len_i = 6'd4;
    arm();
    frm(1); frm(2);
    chk(K_STATE, "rearm_cap", 2); chk(K_WR, "rearm_wr2", 2);
    trig_word_sel_i = 3'd7; trig_mask_i = 32'hFFFFFFFF; trig_pattern_i = 32'h000003FF;
    cyc(1'b1, mkf(3), 1'b0, 1'b1, 1'b0, 1'b0);
    chk(K_STATE, "rearm_armed", 1); chk(K_WR, "rearm_wr0", 0); chk(K_DONE, "rearm_done0", 0);
    frm(5);
    chk(K_STATE, "w7_nomatch", 1);
    cyc(1'b1, ones, 1'b0, 1'b0, 1'b0, 1'b0);
    chk(K_STATE, "w7_match_cap", 2); chk(K_WR, "w7_wr1", 1);
    rd(0, 7, "ones_w7", 32'h000003FF);
    rd(0, 0, "ones_w0", 32'hFFFFFFFF);
    rd(0, 3, "ones_w3", 32'hFFFFFFFF);
    idle(); idle(); idle();

    @(negedge clk40_i); #1;
    if (st_q.size() != 0 || rd_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", st_q.size() + rd_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
